// File: rtl/vga_frota_escalonador.sv
// Fleet position scheduler: fetches one 64-bit vector per ship during vertical
// blanking into a shadow bank, commits the bank atomically, and merges the
// per-ship colour channels into a registered RGB with ship 0 on top.
module vga_frota_escalonador #(
   parameter int unsigned N_NAVIOS  = 5,
   parameter int unsigned LINHA_FIM = 480,
   parameter int unsigned TIMEOUT   = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [9:0]             linha,
   input  logic [9:0]             coluna,
   input  logic                   areaAtiva,
   output logic                   req_valid,
   output logic [2:0]             req_navio,
   input  logic                   resp_valid,
   input  logic [63:0]            resp_posicoes,
   output logic [64*N_NAVIOS-1:0] posicoesFrota,
   input  logic [3*N_NAVIOS-1:0]  rgb_in,
   output logic                   rgb_r,
   output logic                   rgb_g,
   output logic                   rgb_b,
   output logic                   frame_ok,
   output logic                   erro
);

   localparam int unsigned CW = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);
   localparam logic [2:0]    IdxLast = 3'(N_NAVIOS - 1);
   localparam logic [9:0]    LinhaFim = 10'(LINHA_FIM);

   typedef enum logic [2:0] {StIdle, StReq, StWait, StProx, StCommit, StAbort} state_e;

   state_e                 state_q, state_d;
   logic [2:0]             idx_q, idx_d;
   logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
   logic [64*N_NAVIOS-1:0] shadow_q, shadow_d;
   logic [64*N_NAVIOS-1:0] frota_q, frota_d;
   logic                   frame_ok_q, frame_ok_d;
   logic                   erro_q, erro_d;
   logic [2:0]             rgb_q, rgb_merge;
   logic                   tick, abortar;

   assign tick    = (linha == LinhaFim) && (coluna == 10'd0);
   // Active video or a wrapped frame means the fetch window is gone.
   assign abortar = areaAtiva || (linha == 10'd0);
   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

   // Next-state logic: fetch sequencing, shadow capture and commit.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      shadow_d   = shadow_q;
      frota_d    = frota_q;
      frame_ok_d = 1'b0;
      erro_d     = erro_q;
      req_valid  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (tick) begin
               idx_d   = 3'd0;
               state_d = StReq;
            end
         end
         StReq: begin
            req_valid = 1'b1;
            cnt_d     = '0;
            state_d   = abortar ? StAbort : StWait;
         end
         StWait: begin
            if (abortar) begin
               state_d = StAbort;
            end else if (resp_valid) begin
               shadow_d[64*idx_q +: 64] = resp_posicoes;
               state_d = StProx;
            end else if (cnt_inc == CntLast) begin
               // No answer: carry the committed vector forward so the commit stays whole.
               shadow_d[64*idx_q +: 64] = frota_q[64*idx_q +: 64];
               erro_d  = 1'b1;
               state_d = StProx;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         StProx: begin
            if (abortar) begin
               state_d = StAbort;
            end else if (idx_q == IdxLast) begin
               state_d = StCommit;
            end else begin
               idx_d   = idx_q + 3'd1;
               state_d = StReq;
            end
         end
         StCommit: begin
            frota_d    = shadow_q;
            frame_ok_d = 1'b1;
            state_d    = StIdle;
         end
         StAbort: begin
            erro_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Scheduler state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         idx_q      <= 3'd0;
         cnt_q      <= '0;
         shadow_q   <= '0;
         frota_q    <= '0;
         frame_ok_q <= 1'b0;
         erro_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         shadow_q   <= shadow_d;
         frota_q    <= frota_d;
         frame_ok_q <= frame_ok_d;
         erro_q     <= erro_d;
      end
   end

   // Priority merge: scan from the highest index so ship 0 wins last.
   always_comb begin
      rgb_merge = 3'b000;
      for (int i = int'(N_NAVIOS) - 1; i >= 0; i--) begin
         if (rgb_in[3*i +: 3] != 3'b000) rgb_merge = rgb_in[3*i +: 3];
      end
   end

   // Registered colour output, blanked outside the active area.
   always_ff @(posedge clk) begin
      if (rst || !areaAtiva) rgb_q <= 3'b000;
      else                   rgb_q <= rgb_merge;
   end

   assign req_navio     = idx_q;
   assign posicoesFrota = frota_q;
   assign frame_ok      = frame_ok_q;
   assign erro          = erro_q;
   assign rgb_r         = rgb_q[2];
   assign rgb_g         = rgb_q[1];
   assign rgb_b         = rgb_q[0];

endmodule

// File: tb/tb_vga_frota_escalonador.sv
// Self-checking bench: each frame is planned up front from response delays and an
// optional abort point; the plan gives per-cycle expectations checked every cycle.
module tb_vga_frota_escalonador;

   localparam int NN   = 5;
   localparam int TO   = 64;
   localparam int LF   = 480;
   localparam int MAXC = 20000;

   logic             clk, rst;
   logic [9:0]       linha, coluna;
   logic             areaAtiva;
   logic             req_valid;
   logic [2:0]       req_navio;
   logic             resp_valid;
   logic [63:0]      resp_posicoes;
   logic [64*NN-1:0] posicoesFrota;
   logic [3*NN-1:0]  rgb_in;
   logic             rgb_r, rgb_g, rgb_b, frame_ok, erro;

   vga_frota_escalonador #(
      .N_NAVIOS (NN),
      .LINHA_FIM(LF),
      .TIMEOUT  (TO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .linha        (linha),
      .coluna       (coluna),
      .areaAtiva    (areaAtiva),
      .req_valid    (req_valid),
      .req_navio    (req_navio),
      .resp_valid   (resp_valid),
      .resp_posicoes(resp_posicoes),
      .posicoesFrota(posicoesFrota),
      .rgb_in       (rgb_in),
      .rgb_r        (rgb_r),
      .rgb_g        (rgb_g),
      .rgb_b        (rgb_b),
      .frame_ok     (frame_ok),
      .erro         (erro)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Per-cycle plan, indexed by absolute cycle number.
   bit          exp_rv     [MAXC];
   logic [2:0]  exp_nav    [MAXC];
   bit          evt_commit [MAXC];
   bit          evt_erro   [MAXC];
   bit          d_resp     [MAXC];
   bit          d_area     [MAXC];
   logic [63:0] d_data     [MAXC];

   logic [63:0] plan_nv   [NN];
   logic [63:0] exp_frota [NN];
   int          plan_dly  [NN];
   logic [63:0] plan_dat  [NN];
   int          plan_rt   [NN];
   int          win_lo = -1;
   int          win_hi = -1;
   int          q_cyc[$];
   int          q_nav[$];
   int          fok_cnt = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, cyc, act, expv);
      end
   endtask

   function automatic logic [2:0] ref_merge(input logic [3*NN-1:0] v, input logic area);
      logic [2:0] s;
      if (!area) return 3'b000;
      for (int i = 0; i < NN; i++) begin
         s = v[3*i +: 3];
         if (s != 3'b000) return s;
      end
      return 3'b000;
   endfunction

   // Compare process: apply planned events for this cycle, then check every output.
   initial begin : compare
      bit         armed, rst_prev, exp_fok, exp_erro, erv;
      logic [2:0] exp_rgb;
      armed = 0; rst_prev = 0; exp_fok = 0; exp_erro = 0; exp_rgb = 3'b000;
      foreach (exp_frota[i]) exp_frota[i] = '0;
      forever begin
         @(negedge clk);
         if (armed) begin
            if (rst_prev) begin
               exp_fok  = 0;
               exp_erro = 0;
               foreach (exp_frota[i]) exp_frota[i] = '0;
            end else begin
               exp_fok = evt_commit[cyc];
               if (evt_commit[cyc]) foreach (exp_frota[i]) exp_frota[i] = plan_nv[i];
               if (evt_erro[cyc]) exp_erro = 1;
            end
            erv = rst_prev ? 1'b0 : exp_rv[cyc];
            chk("req_valid", req_valid, erv);
            if (erv) chk("req_navio", req_navio, exp_nav[cyc]);
            else if (rst_prev) chk("req_navio_rst", req_navio, 0);
            chk("frame_ok", frame_ok, exp_fok);
            chk("erro", erro, exp_erro);
            for (int i = 0; i < NN; i++) chk("posicoesFrota", posicoesFrota[64*i +: 64], exp_frota[i]);
            chk("rgb", {rgb_r, rgb_g, rgb_b}, exp_rgb);
            if (req_valid === 1'b1) begin
               q_cyc.push_back(cyc);
               q_nav.push_back(int'(req_navio));
            end
            if (frame_ok === 1'b1) fok_cnt++;
         end
         exp_rgb  = rst ? 3'b000 : ref_merge(rgb_in, areaAtiva);
         rst_prev = rst;
         if (rst) armed = 1;
      end
   end

   // Advance one cycle and drive inputs for the new cycle.
   task automatic step(input bit r);
      @(posedge clk);
      #1;
      if (cyc > MAXC - 700) begin
         errors++;
         $display("FAIL cycle_budget @cycle %0d: got exhausted, expected below %0d", cyc, MAXC - 700);
         $display("Simulation finished: %0d checks, %0d errors", checks, errors);
         $fatal(1);
      end
      rst = r;
      for (int i = 0; i < NN; i++)
         rgb_in[3*i +: 3] = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'b000;
      resp_valid    = d_resp[cyc];
      resp_posicoes = d_resp[cyc] ? d_data[cyc] : {$urandom, $urandom};
      coluna        = 10'($urandom_range(1, 799));
      if (d_area[cyc]) begin
         areaAtiva = 1'b1;
         linha     = 10'($urandom_range(481, 524));
      end else if (cyc >= win_lo && cyc <= win_hi) begin
         areaAtiva = 1'b0;
         linha     = 10'($urandom_range(481, 524));
      end else begin
         areaAtiva = 1'($urandom_range(0, 1));
         linha     = 10'($urandom_range(0, 1023));
         if (!resp_valid) resp_valid = ($urandom_range(0, 7) == 0);
      end
   endtask

   // Plan one frame from plan_dly/plan_dat, drive the tick, and run it to completion.
   task automatic run_frame(input int ab_ship, input int ab_off, input int rst_ship,
                            output int t0);
      int r, w, cmt, a, rr;
      step(0);
      t0 = cyc;
      q_cyc.delete();
      q_nav.delete();
      fok_cnt = 0;
      r = t0 + 1;
      for (int i = 0; i < NN; i++) begin
         plan_rt[i] = r;
         w = (plan_dly[i] > 0) ? plan_dly[i] : TO - 1;
         r = r + w + 2;
      end
      cmt = r;
      a = (ab_ship >= 0) ? plan_rt[ab_ship] + ab_off : -1;
      for (int i = 0; i < NN; i++) begin
         if (a < 0 || plan_rt[i] <= a) begin
            exp_rv[plan_rt[i]]  = 1;
            exp_nav[plan_rt[i]] = 3'(i);
         end
         if (plan_dly[i] > 0) begin
            d_resp[plan_rt[i] + plan_dly[i]] = 1;
            d_data[plan_rt[i] + plan_dly[i]] = plan_dat[i];
            plan_nv[i] = plan_dat[i];
         end else begin
            plan_nv[i] = exp_frota[i];
            if (a < 0 || plan_rt[i] + TO - 1 < a) evt_erro[plan_rt[i] + TO] = 1;
         end
      end
      if (a >= 0) begin
         d_area[a]     = 1;
         evt_erro[a+2] = 1;
         win_hi        = a - 1;
      end else begin
         evt_commit[cmt+1] = 1;
         win_hi            = cmt;
      end
      win_lo = t0 + 1;
      linha  = 10'(LF);
      coluna = 10'd0;
      rr = (rst_ship >= 0) ? plan_rt[rst_ship] + 1 : -1;
      while (cyc < cmt + 3) begin
         if (cyc + 1 == rr) begin
            for (int c = rr + 1; c <= cmt + 3; c++) begin
               exp_rv[c] = 0;
               evt_commit[c] = 0;
               evt_erro[c] = 0;
            end
            step(1);
         end else begin
            step(0);
         end
      end
   endtask

   task automatic set_nominal();
      for (int i = 0; i < NN; i++) begin
         plan_dly[i] = 1;
         plan_dat[i] = 64'((i << 3) | 'h44);
      end
   endtask

   initial begin : main
      int t0, abs, abo, w;
      rst = 1'b1; linha = 10'd1; coluna = 10'd1; areaAtiva = 1'b0;
      resp_valid = 1'b0; resp_posicoes = '0; rgb_in = '0;

      step(1);
      chk("rst_req_valid", req_valid, 0);
      chk("rst_req_navio", req_navio, 0);
      chk("rst_frota", posicoesFrota, 0);
      chk("rst_erro", erro, 0);
      chk("rst_frame_ok", frame_ok, 0);
      chk("rst_rgb", {rgb_r, rgb_g, rgb_b}, 0);
      step(1);
      repeat (3) step(0);

      // Priority merge, directed.
      step(0);
      areaAtiva = 1'b1; rgb_in = '0; rgb_in[5:3] = 3'b110; rgb_in[11:9] = 3'b101;
      step(0);
      chk("merge_prio", {rgb_r, rgb_g, rgb_b}, 3'b110);
      areaAtiva = 1'b0; rgb_in = '0; rgb_in[5:3] = 3'b110; rgb_in[11:9] = 3'b101;
      step(0);
      chk("merge_blank", {rgb_r, rgb_g, rgb_b}, 3'b000);

      // Nominal fetch.
      set_nominal();
      run_frame(-1, 0, -1, t0);
      chk("nom_req_count", q_nav.size(), 5);
      for (int k = 0; k < q_nav.size(); k++) chk("nom_req_navio", q_nav[k], k);
      if (q_cyc.size() > 0) chk("nom_first_req", q_cyc[0] - t0, 1);
      for (int k = 1; k < q_cyc.size(); k++) chk("nom_req_spacing", q_cyc[k] - q_cyc[k-1], 3);
      chk("nom_slice2", posicoesFrota[191:128], 64'h54);
      chk("nom_erro", erro, 0);
      chk("nom_fok_count", fok_cnt, 1);

      // Preload ship 1, then let ship 1 time out.
      for (int i = 0; i < NN; i++) begin
         plan_dly[i] = 1;
         plan_dat[i] = {$urandom, $urandom};
      end
      plan_dat[1] = 64'h88;
      run_frame(-1, 0, -1, t0);
      chk("pre_slice1", posicoesFrota[127:64], 64'h88);
      for (int i = 0; i < NN; i++) begin
         plan_dly[i] = $urandom_range(1, 5);
         plan_dat[i] = {$urandom, $urandom};
      end
      plan_dly[1] = 0;
      run_frame(-1, 0, -1, t0);
      if (q_cyc.size() == 5) chk("to_req_gap", q_cyc[2] - q_cyc[1], 65);
      else chk("to_req_count", q_cyc.size(), 5);
      chk("to_slice1", posicoesFrota[127:64], 64'h88);
      chk("to_erro", erro, 1);
      chk("to_fok_count", fok_cnt, 1);

      // Clean slate, nominal frame, then abort during ship 2 with a late response.
      step(1);
      repeat (3) step(0);
      set_nominal();
      run_frame(-1, 0, -1, t0);
      chk("ab_pre_erro", erro, 0);
      for (int i = 0; i < NN; i++) plan_dat[i] = {$urandom, $urandom};
      plan_dly[2] = 10;
      run_frame(2, 3, -1, t0);
      chk("ab_slice0", posicoesFrota[63:0], 64'h44);
      chk("ab_slice2", posicoesFrota[191:128], 64'h54);
      chk("ab_fok_count", fok_cnt, 0);
      chk("ab_erro", erro, 1);
      chk("ab_req_count", q_nav.size(), 3);

      // Reset while waiting on ship 3.
      for (int i = 0; i < NN; i++) begin
         plan_dly[i] = $urandom_range(1, 6);
         plan_dat[i] = {$urandom, $urandom};
      end
      run_frame(-1, 0, 3, t0);
      chk("rm_req_valid", req_valid, 0);
      chk("rm_frota", posicoesFrota, 0);
      chk("rm_erro", erro, 0);
      chk("rm_fok_count", fok_cnt, 0);
      q_cyc.delete();
      q_nav.delete();
      repeat (60) step(0);
      chk("rm_no_req", q_nav.size(), 0);
      set_nominal();
      run_frame(-1, 0, -1, t0);
      chk("rm_restart_slice2", posicoesFrota[191:128], 64'h54);

      // Randomized frames.
      for (int f = 0; f < 16; f++) begin
         for (int i = 0; i < NN; i++) begin
            if ($urandom_range(0, 7) == 0)      plan_dly[i] = 0;
            else if ($urandom_range(0, 1) == 0) plan_dly[i] = $urandom_range(1, 4);
            else                                plan_dly[i] = $urandom_range(1, TO - 1);
            plan_dat[i] = {$urandom, $urandom};
         end
         abs = -1;
         abo = 0;
         if ($urandom_range(0, 3) == 0) begin
            abs = $urandom_range(0, NN - 1);
            w   = (plan_dly[abs] > 0) ? plan_dly[abs] : TO - 1;
            abo = $urandom_range(0, w + 1);
         end
         run_frame(abs, abo, -1, t0);
         repeat ($urandom_range(0, 5)) step(0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
